// File: rtl/demux_1_8_pkg.sv
// -----------------------------------------------------------------------------
// demux_1_8_pkg
// Shared constants and types for the registered 1:8 demultiplexer.
//   NUM_OUTPUTS : number of routed outputs (8)
//   SEL_WIDTH   : width of the output-select code (3)
//   sel_t       : select code type
//   SEL_OUT0..7 : select codes naming each output
// -----------------------------------------------------------------------------
package demux_1_8_pkg;

   localparam int NUM_OUTPUTS = 8;
   localparam int SEL_WIDTH   = 3;

   typedef logic [SEL_WIDTH-1:0] sel_t;

   localparam sel_t SEL_OUT0 = 3'd0;
   localparam sel_t SEL_OUT1 = 3'd1;
   localparam sel_t SEL_OUT2 = 3'd2;
   localparam sel_t SEL_OUT3 = 3'd3;
   localparam sel_t SEL_OUT4 = 3'd4;
   localparam sel_t SEL_OUT5 = 3'd5;
   localparam sel_t SEL_OUT6 = 3'd6;
   localparam sel_t SEL_OUT7 = 3'd7;

endpackage

// File: rtl/demux_1_8_decoder.sv
// -----------------------------------------------------------------------------
// demux_1_8_decoder
// Combinational 3-to-8 one-hot decoder with enable.
// Ports:
//   i_enable : decoder enable; 0 forces an all-zero output
//   i_select : output index 0..7
//   o_onehot : one-hot vector, bit k set when enabled and i_select == k
// -----------------------------------------------------------------------------
module demux_1_8_decoder
   import demux_1_8_pkg::*;
(
   input  logic                   i_enable,
   input  sel_t                   i_select,
   output logic [NUM_OUTPUTS-1:0] o_onehot
);

   logic [NUM_OUTPUTS-1:0] w_onehot;

   always_comb begin
      w_onehot = '0;
      if (i_enable) begin
         case (i_select)
            SEL_OUT0: w_onehot = 8'b0000_0001;
            SEL_OUT1: w_onehot = 8'b0000_0010;
            SEL_OUT2: w_onehot = 8'b0000_0100;
            SEL_OUT3: w_onehot = 8'b0000_1000;
            SEL_OUT4: w_onehot = 8'b0001_0000;
            SEL_OUT5: w_onehot = 8'b0010_0000;
            SEL_OUT6: w_onehot = 8'b0100_0000;
            SEL_OUT7: w_onehot = 8'b1000_0000;
            default:  w_onehot = '0;
         endcase
      end
   end

   assign o_onehot = w_onehot;

endmodule

// File: rtl/demux_1_8.sv
// -----------------------------------------------------------------------------
// demux_1_8
// Registered 1:8 demultiplexer. Data_In is routed to Data_<Select_In>_Out on
// the rising edge of Clock_In when Enable_In is high; one cycle of latency.
// Ports:
//   Clock_In               : system clock, rising-edge active
//   Reset_N_In             : asynchronous active-low reset, clears all outputs
//   Enable_In              : routing enable
//   Data_In                : data to route (DATA_WIDTH bits)
//   Select_In              : output index 0..7
//   Data_0_Out..Data_7_Out : registered routed outputs (DATA_WIDTH bits each)
// Configuration macro DEMUX_1_8_HOLD_EN:
//   undefined : every non-selected output (and all outputs when disabled)
//               clears to 0 at each edge
//   defined   : non-selected outputs, and all outputs when disabled, keep
//               their previous values
// -----------------------------------------------------------------------------
module demux_1_8
   import demux_1_8_pkg::*;
#(
   parameter int DATA_WIDTH = 1
) (
   input  logic                  Clock_In,
   input  logic                  Reset_N_In,
   input  logic                  Enable_In,
   input  logic [DATA_WIDTH-1:0] Data_In,
   input  logic [SEL_WIDTH-1:0]  Select_In,
   output logic [DATA_WIDTH-1:0] Data_0_Out,
   output logic [DATA_WIDTH-1:0] Data_1_Out,
   output logic [DATA_WIDTH-1:0] Data_2_Out,
   output logic [DATA_WIDTH-1:0] Data_3_Out,
   output logic [DATA_WIDTH-1:0] Data_4_Out,
   output logic [DATA_WIDTH-1:0] Data_5_Out,
   output logic [DATA_WIDTH-1:0] Data_6_Out,
   output logic [DATA_WIDTH-1:0] Data_7_Out
);

   logic [NUM_OUTPUTS-1:0] w_onehot;
   logic [DATA_WIDTH-1:0]  r_data [NUM_OUTPUTS];

   demux_1_8_decoder u_decoder (
      .i_enable (Enable_In),
      .i_select (Select_In),
      .o_onehot (w_onehot)
   );

   always_ff @(posedge Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         for (int k = 0; k < NUM_OUTPUTS; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_OUTPUTS; k++) begin
`ifdef DEMUX_1_8_HOLD_EN
            // Only the selected register loads; the rest keep their contents.
            if (w_onehot[k]) begin
               r_data[k] <= Data_In;
            end
`else
            // Each register takes Data_In when selected, otherwise clears.
            r_data[k] <= w_onehot[k] ? Data_In : '0;
`endif
         end
      end
   end

   assign Data_0_Out = r_data[0];
   assign Data_1_Out = r_data[1];
   assign Data_2_Out = r_data[2];
   assign Data_3_Out = r_data[3];
   assign Data_4_Out = r_data[4];
   assign Data_5_Out = r_data[5];
   assign Data_6_Out = r_data[6];
   assign Data_7_Out = r_data[7];

endmodule

// File: tb/tb_demux_1_8.sv
// -----------------------------------------------------------------------------
// tb_demux_1_8
// Self-checking bench for demux_1_8. A behavioural model holds the expected
// value of each of the eight outputs and is updated once per rising edge from
// the routing rules; every output is compared after each edge.
// Honours DEMUX_1_8_HOLD_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_demux_1_8;

   localparam int W = 4;

   logic         Clock_In;
   logic         Reset_N_In;
   logic         Enable_In;
   logic [W-1:0] Data_In;
   logic [2:0]   Select_In;
   logic [W-1:0] Data_0_Out, Data_1_Out, Data_2_Out, Data_3_Out;
   logic [W-1:0] Data_4_Out, Data_5_Out, Data_6_Out, Data_7_Out;

   logic [W-1:0] outs [8];
   logic [W-1:0] exp_q [8];

   int n_cmp = 0;
   int n_bad = 0;

   demux_1_8 #(.DATA_WIDTH(W)) dut (
      .Clock_In   (Clock_In),
      .Reset_N_In (Reset_N_In),
      .Enable_In  (Enable_In),
      .Data_In    (Data_In),
      .Select_In  (Select_In),
      .Data_0_Out (Data_0_Out),
      .Data_1_Out (Data_1_Out),
      .Data_2_Out (Data_2_Out),
      .Data_3_Out (Data_3_Out),
      .Data_4_Out (Data_4_Out),
      .Data_5_Out (Data_5_Out),
      .Data_6_Out (Data_6_Out),
      .Data_7_Out (Data_7_Out)
   );

   assign outs[0] = Data_0_Out;
   assign outs[1] = Data_1_Out;
   assign outs[2] = Data_2_Out;
   assign outs[3] = Data_3_Out;
   assign outs[4] = Data_4_Out;
   assign outs[5] = Data_5_Out;
   assign outs[6] = Data_6_Out;
   assign outs[7] = Data_7_Out;

   initial Clock_In = 1'b0;
   always #5 Clock_In = ~Clock_In;

   // Expected effect of one rising edge on the eight outputs.
   task automatic model_edge(input logic en, input logic [W-1:0] d, input int sel);
`ifndef DEMUX_1_8_HOLD_EN
      for (int k = 0; k < 8; k++) exp_q[k] = '0;
`endif
      if (en) exp_q[sel] = d;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) exp_q[k] = '0;
   endtask

   task automatic check_one(input string tag, input logic [W-1:0] obs, input logic [W-1:0] req);
      n_cmp++;
      assert (obs === req) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 8; k++) begin
         check_one($sformatf("%s out%0d", tag, k), outs[k], exp_q[k]);
      end
   endtask

   // Drive inputs away from the edge, take one edge, then compare.
   task automatic cycle(input string tag, input logic en, input logic [W-1:0] d, input int sel);
      Enable_In = en;
      Data_In   = d;
      Select_In = 3'(sel);
      @(posedge Clock_In);
      if (Reset_N_In) model_edge(en, d, sel);
      #1;
      check_all(tag);
   endtask

   initial begin
      Reset_N_In = 1'b1;
      Enable_In  = 1'b0;
      Data_In    = '0;
      Select_In  = '0;
      model_reset();

      // Power-on reset
      #2 Reset_N_In = 1'b0;
      #1 check_all("por");
      cycle("por_held", 1'b1, 4'hF, 4);
      Reset_N_In = 1'b1;
      cycle("por_rel", 1'b0, 4'hF, 4);

      // Disabled path
      cycle("dis_prime", 1'b1, 4'h1, 5);
      for (int i = 0; i < 3; i++) cycle("disabled", 1'b0, 4'h1, 5);

      // Walking select
      for (int s = 0; s < 8; s++) cycle($sformatf("walk%0d", s), 1'b1, 4'h1, s);

      // Zero data
      cycle("zero_data", 1'b1, 4'h0, 3);

      // Random sweep, enable high
      for (int i = 0; i < 20; i++) begin
         cycle("rand_en", 1'b1, W'($urandom_range(1, 15)), int'($urandom_range(0, 7)));
      end
      // Random sweep, random enable
      for (int i = 0; i < 20; i++) begin
         cycle("rand_mix", 1'($urandom), W'($urandom), int'($urandom_range(0, 7)));
      end

      // Asynchronous reset mid-cycle with an output non-zero
      cycle("rst_prime", 1'b1, 4'hA, 6);
      check_one("rst_prime_nz", Data_6_Out, 4'hA);
      #2 Reset_N_In = 1'b0;
      model_reset();
      #1 check_all("rst_async");
      cycle("rst_held", 1'b1, 4'h7, 1);
      Reset_N_In = 1'b1;
      cycle("rst_rel", 1'b0, 4'h7, 1);
      cycle("rst_first", 1'b1, 4'h7, 1);

`ifdef DEMUX_1_8_HOLD_EN
      // Hold mode: earlier selections persist
      cycle("hold_a", 1'b1, 4'h1, 2);
      cycle("hold_b", 1'b1, 4'h1, 6);
      check_one("hold_out2", Data_2_Out, 4'h1);
      check_one("hold_out6", Data_6_Out, 4'h1);
      cycle("hold_dis", 1'b0, 4'h9, 0);
      #2 Reset_N_In = 1'b0;
      model_reset();
      #1 check_all("hold_rst");
      Reset_N_In = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
